mspulse_multi: RTL and testbench
================================

Name: mspulse_multi

Overview:
- Parametrised successor to the single-channel millisecond pulse generator.
- One shared prescaler derives a tick strobe (default 1 kHz) from the system clock.
- NCH independent channels each count a programmable number of ticks and emit a one-cycle pulse, in one-shot or continuous mode, under start/stop control.
- Drives LED/heartbeat logic and timed events at the board top level.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 1000, tick rate in Hz. DIV = CLK_HZ/TICK_HZ, integer division; DIV >= 2 is required (elaboration error otherwise).
- NCH, 4, number of channels (1..16).
- CNT_W, 16, width of each channel's period field in ticks.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  NCH  per-channel start/restart request, level-sampled each cycle.
- stop  in  NCH  per-channel stop request, level-sampled each cycle.
- oneshot  in  NCH  per-channel mode: 1 = one-shot, 0 = continuous; latched at start.
- period  in  NCH*CNT_W  per-channel period in ticks, channel i at bits [i*CNT_W +: CNT_W]; latched at start.
- tick  out  1  one-cycle strobe at TICK_HZ.
- msclock  out  1  square wave, toggles on every tick (period = 2 ticks).
- pulse  out  NCH  one-cycle pulse at channel period expiry.
- busy  out  NCH  channel running.
- done  out  NCH  one-cycle strobe when a one-shot channel completes.

Behaviour:
- Reset, synchronous and active-high, takes priority over everything. Values in the cycle after reset is sampled high:
  - prescaler = 0, tick = 0, msclock = 0;
  - every channel IDLE, with cnt = 0, pulse = 0, busy = 0, done = 0.
- Prescaler:
  - Free-running counter 0..DIV-1, independent of channel activity.
  - tick is registered: high for exactly one cycle, in the cycle after the prescaler holds DIV-1. The first tick after reset release therefore appears DIV cycles after the first non-reset edge.
  - msclock toggles on the same edge at which tick rises.
- Per-channel FSM, states IDLE and RUN. Priority per cycle is reset > stop > start > tick.
  - IDLE, start=1, period!=0: go to RUN; cnt <= period; mode <= oneshot; busy=1 from the next cycle.
  - IDLE, start=1, period==0: request ignored; stay IDLE and raise no pulse or done.
  - RUN, stop=1: go to IDLE next cycle with busy=0. No pulse or done, even if tick=1 in the same cycle.
  - RUN, start=1, no stop: restart. Reload cnt and mode from the inputs; any coincident tick is not counted. The prescaler is not reset. A restart with period==0 behaves as stop.
  - RUN, tick=1, cnt>1: cnt <= cnt-1.
  - RUN, tick=1, cnt==1: pulse[i]=1 in the next cycle only.
    - Continuous mode: cnt <= latched period and stay in RUN.
    - One-shot mode: done[i]=1 in the same cycle as the pulse, then IDLE; busy falls in that same cycle.
- Latency:
  - A start sampled at edge n makes the channel count ticks that are high in cycles >= n+1.
  - The pulse occurs one cycle after the Pth such tick. The first interval therefore spans between (P-1)*DIV+1 and P*DIV clock cycles after start, depending on prescaler phase.
  - Subsequent continuous pulses are exactly P*DIV cycles apart.
- period and oneshot are sampled only when a start is accepted. Later changes have no effect until the next start.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- Maximum period is 2^CNT_W-1 ticks. cnt never wraps.

Test Plan:
- All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), NCH=2, CNT_W=4.
- Reset then idle 40 cycles:
  - tick high one cycle every 10 cycles, first 10 cycles after release;
  - msclock toggles on each tick;
  - pulse, busy and done stay 0.
- Ch0 continuous, period=3:
  - start one cycle -> busy=1 next cycle;
  - pulses exactly 30 cycles apart after the first;
  - the first pulse falls 21..30 cycles after start.
- Ch1 one-shot, period=2:
  - exactly one pulse, with done high in the same cycle;
  - busy drops with it;
  - no further pulse over 50 cycles.
- Stop during RUN, with stop asserted in the cycle tick=1 and cnt==1: no pulse, busy=0 next cycle. Separately, start with period=0 in IDLE: busy stays 0.
- Ch0 running with cnt==1: assert start with period=5 in the tick cycle. Required response:
  - no pulse from that tick;
  - the next pulse comes after 5 further ticks;
  - ch1 is unaffected throughout.
- Assert reset mid-RUN on both channels: all outputs 0 next cycle, prescaler restarts, a later start behaves as from cold.

Source files
------------

// File: rtl/mspulse_multi.sv
// Multi-channel millisecond pulse generator: one shared prescaler produces a tick
// strobe and square wave, and NCH channels count ticks to emit period pulses.
module mspulse_multi #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned NCH     = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         start,
    input  logic [NCH-1:0]         stop,
    input  logic [NCH-1:0]         oneshot,
    input  logic [NCH*CNT_W-1:0]   period,
    output logic                   tick,
    output logic                   msclock,
    output logic [NCH-1:0]         pulse,
    output logic [NCH-1:0]         busy,
    output logic [NCH-1:0]         done
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("mspulse_multi: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (NCH < 1 || NCH > 16) begin : g_nch_chk
        $error("mspulse_multi: NCH must be in 1..16");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    logic [PS_W-1:0]             ps_q, ps_d;
    logic                        tick_q, tick_d;
    logic                        msclock_q, msclock_d;

    state_e                      state_q [NCH];
    state_e                      state_d [NCH];
    logic [NCH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0][CNT_W-1:0]   per_q, per_d;
    logic [NCH-1:0]              mode_q, mode_d;
    logic [NCH-1:0]              pulse_q, pulse_d;
    logic [NCH-1:0]              busy_q, busy_d;
    logic [NCH-1:0]              done_q, done_d;

    // Free-running prescaler; tick registers the terminal count
    always_comb begin
        ps_d      = (ps_q == PS_MAX) ? '0 : ps_q + PS_W'(1);
        tick_d    = (ps_q == PS_MAX);
        msclock_d = msclock_q ^ tick_d;
    end

    // Per-channel next state: stop beats start beats tick
    always_comb begin
        logic [CNT_W-1:0] per_in;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            per_d[i]   = per_q[i];
            mode_d[i]  = mode_q[i];
            pulse_d[i] = 1'b0;
            done_d[i]  = 1'b0;
            per_in     = period[i*CNT_W +: CNT_W];
            case (state_q[i])
                S_IDLE: begin
                    if (!stop[i] && start[i] && per_in != '0) begin
                        state_d[i] = S_RUN;
                        cnt_d[i]   = per_in;
                        per_d[i]   = per_in;
                        mode_d[i]  = oneshot[i];
                    end
                end
                S_RUN: begin
                    if (stop[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (start[i]) begin
                        // Restart with a zero period is treated as a stop
                        if (per_in != '0) begin
                            cnt_d[i]  = per_in;
                            per_d[i]  = per_in;
                            mode_d[i] = oneshot[i];
                        end else begin
                            state_d[i] = S_IDLE;
                            cnt_d[i]   = '0;
                        end
                    end else if (tick_q) begin
                        if (cnt_q[i] > CNT_W'(1)) begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end else begin
                            pulse_d[i] = 1'b1;
                            if (mode_q[i]) begin
                                done_d[i]  = 1'b1;
                                state_d[i] = S_IDLE;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i] = per_q[i];
                            end
                        end
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            busy_d[i] = (state_d[i] == S_RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q      <= '0;
            tick_q    <= 1'b0;
            msclock_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
            end
            cnt_q     <= '0;
            per_q     <= '0;
            mode_q    <= '0;
            pulse_q   <= '0;
            busy_q    <= '0;
            done_q    <= '0;
        end else begin
            ps_q      <= ps_d;
            tick_q    <= tick_d;
            msclock_q <= msclock_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
            end
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            mode_q    <= mode_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tick    = tick_q;
    assign msclock = msclock_q;
    assign pulse   = pulse_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mspulse_multi.sv
// Directed bench for mspulse_multi with DIV=10, two 4-bit channels; k counts
// clock edges since the last reset release and all expectations are keyed to it.
module tb_mspulse_multi;

    logic       clk;
    logic       reset;
    logic [1:0] start;
    logic [1:0] stop;
    logic [1:0] oneshot;
    logic [7:0] period;
    logic       tick;
    logic       msclock;
    logic [1:0] pulse;
    logic [1:0] busy;
    logic [1:0] done;

    int k;
    int nvec;
    int nerr;

    mspulse_multi #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .NCH    (2),
        .CNT_W  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .oneshot(oneshot),
        .period (period),
        .tick   (tick),
        .msclock(msclock),
        .pulse  (pulse),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        k = k + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec = nvec + 1;
        assert (got === exp) else begin
            nerr = nerr + 1;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Step up to edge `target`; no pulse or done may appear on the way
    task automatic run_to(input int target, input string tag);
        logic [1:0] seen;
        seen = 2'b00;
        while (k < target) begin
            step();
            seen = seen | pulse | done;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [1:0] idle_seen;
        logic       early_tick;
        int         lat;
        k       = 0;
        nvec    = 0;
        nerr    = 0;
        reset   = 1'b1;
        start   = 2'b00;
        stop    = 2'b00;
        oneshot = 2'b00;
        period  = 8'h00;

        step();
        step();
        chk("rst_tick",    32'(tick),    32'd0);
        chk("rst_msclock", 32'(msclock), 32'd0);
        chk("rst_pulse",   32'(pulse),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        reset = 1'b0;
        k     = 0;

        // Idle: tick every 10 cycles, msclock toggling, channels silent
        idle_seen = 2'b00;
        for (int n = 1; n <= 40; n++) begin
            step();
            chk("idle_tick",    32'(tick),    32'((k % 10) == 0));
            chk("idle_msclock", 32'(msclock), 32'((k / 10) % 2));
            idle_seen = idle_seen | pulse | busy | done;
        end
        chk("idle_quiet", 32'(idle_seen), 32'd0);

        // Ch0 continuous P=3, started in a tick cycle (k=40)
        start   = 2'b01;
        period  = 8'h03;
        oneshot = 2'b00;
        step();
        start  = 2'b00;
        period = 8'hF9;
        chk("c0_busy", 32'(busy), 32'h1);
        run_to(70, "c0_quiet1");
        step();
        chk("c0_pulse1", 32'(pulse), 32'h1);
        lat = k - 41;
        chk("c0_first_lat", 32'(lat >= 21 && lat <= 30), 32'd1);
        run_to(100, "c0_quiet2");
        step();
        chk("c0_pulse2", 32'(pulse), 32'h1);
        run_to(130, "c0_quiet3");
        step();
        chk("c0_pulse3", 32'(pulse), 32'h1);

        // Ch1 one-shot P=2 while ch0 keeps running
        start   = 2'b10;
        period  = 8'h20;
        oneshot = 2'b10;
        step();
        start   = 2'b00;
        period  = 8'hF0;
        oneshot = 2'b00;
        chk("c1_busy", 32'(busy), 32'h3);
        run_to(150, "c1_quiet");
        step();
        chk("c1_pulse", 32'(pulse), 32'h2);
        chk("c1_done",  32'(done),  32'h2);
        chk("c1_busy_drop", 32'(busy), 32'h1);

        // Stop ch0 in the cycle where tick=1 and cnt==1
        run_to(160, "stop_pre");
        chk("stop_tick", 32'(tick), 32'd1);
        stop = 2'b01;
        step();
        stop = 2'b00;
        chk("stop_pulse", 32'(pulse), 32'd0);
        chk("stop_busy",  32'(busy),  32'd0);
        chk("stop_done",  32'(done),  32'd0);
        run_to(211, "oneshot_no_repeat");
        chk("post_busy", 32'(busy), 32'd0);

        // Start with zero period from IDLE is ignored
        start  = 2'b01;
        period = 8'h00;
        step();
        start = 2'b00;
        chk("p0_busy", 32'(busy), 32'd0);
        step();
        chk("p0_busy2", 32'(busy),  32'd0);
        chk("p0_pulse", 32'(pulse), 32'd0);

        // Ch0 P=2 and ch1 P=4 continuous, then restart ch0 with P=5 at cnt==1
        start   = 2'b11;
        period  = 8'h42;
        oneshot = 2'b00;
        step();
        start  = 2'b00;
        period = 8'hFF;
        chk("rs_busy", 32'(busy), 32'h3);
        run_to(230, "rs_pre");
        chk("rs_tick", 32'(tick), 32'd1);
        start  = 2'b01;
        period = 8'h05;
        step();
        start  = 2'b00;
        period = 8'hFF;
        chk("rs_no_pulse", 32'(pulse), 32'd0);
        chk("rs_busy2",    32'(busy),  32'h3);
        run_to(250, "rs_quiet1");
        step();
        chk("rs_c1_pulse1", 32'(pulse), 32'h2);
        run_to(280, "rs_quiet2");
        step();
        chk("rs_c0_pulse", 32'(pulse), 32'h1);
        run_to(290, "rs_quiet3");
        step();
        chk("rs_c1_pulse2", 32'(pulse), 32'h2);

        // Reset mid-run on both channels, then a cold start
        reset = 1'b1;
        step();
        chk("mr_tick",    32'(tick),    32'd0);
        chk("mr_msclock", 32'(msclock), 32'd0);
        chk("mr_pulse",   32'(pulse),   32'd0);
        chk("mr_busy",    32'(busy),    32'd0);
        chk("mr_done",    32'(done),    32'd0);
        reset   = 1'b0;
        k       = 0;
        start   = 2'b01;
        period  = 8'h01;
        oneshot = 2'b01;
        step();
        start   = 2'b00;
        oneshot = 2'b00;
        chk("cold_busy", 32'(busy), 32'h1);
        early_tick = tick;
        while (k < 9) begin
            step();
            early_tick = early_tick | tick;
        end
        chk("cold_no_early_tick", 32'(early_tick), 32'd0);
        step();
        chk("cold_tick",    32'(tick),    32'd1);
        chk("cold_msclock", 32'(msclock), 32'd1);
        step();
        chk("cold_pulse", 32'(pulse), 32'h1);
        chk("cold_done",  32'(done),  32'h1);
        chk("cold_busy2", 32'(busy),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
